// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller_pkg
// Description : Shared definitions for the interrupt controller: sequencer
//               state encoding, register offsets and CAUSE layout.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_controller_pkg;

  // Sequencer states: waiting, requesting the core, core in handler
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } irqc_state_t;

  // Register offsets on the data bus
  localparam logic [1:0] c_addr_pend  = 2'd0;
  localparam logic [1:0] c_addr_mask  = 2'd1;
  localparam logic [1:0] c_addr_cause = 2'd2;
  localparam logic [1:0] c_addr_ctrl  = 2'd3;

  // CAUSE bit carrying the in-service flag
  localparam int c_cause_insvc_bit = 31;

endpackage : irq_controller_pkg
`default_nettype wire

// File: rtl/irq_controller_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller_prio_enc
// Description : Combinational fixed-priority encoder; the lowest set bit of
//               act wins.
// Ports       : act   in  NSRC  active (pending & enabled) sources
//               id    out ID_W  index of the lowest set bit (0 when none)
//               valid out 1     at least one bit of act is set
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller_prio_enc #(
  parameter int NSRC = 4,
  parameter int ID_W = 2
) (
  input  logic [NSRC-1:0] act,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule : irq_controller_prio_enc
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Edge-triggered interrupt controller for the mips core. Latches
//               source rising edges as pending, applies mask and global
//               enable, and sequences one interrupt at a time using the
//               core's iack (handler entered) and ret (rfe) pulses.
// Ports       : clk     in  1     system clock
//               rst     in  1     asynchronous active-high reset
//               src_req in  NSRC  interrupt request levels
//               irq     out 1     interrupt request to the core
//               iack    in  1     core has vectored to the handler
//               ret     in  1     core executed rfe
//               we      in  1     bus write strobe
//               addr    in  2     0 PEND, 1 MASK, 2 CAUSE, 3 CTRL
//               wd      in  32    bus write data
//               rd      out 32    bus read data (combinational from addr)
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_req,
  output logic            irq,
  input  logic            iack,
  input  logic            ret,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd
);

  logic [NSRC-1:0] r_src_d;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic            r_gie;
  logic [ID_W-1:0] r_cause;
  irqc_state_t     r_state;
  irqc_state_t     w_state_nxt;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_act;
  logic            w_req;
  logic [ID_W-1:0] w_win_id;
  logic            w_win_vld;
  logic            w_take;
  logic [NSRC-1:0] w_take_clr;
  logic [NSRC-1:0] w_bus_clr;
  logic            w_unused_wd;

  assign w_unused_wd = ^wd;

  assign w_rise = src_req & ~r_src_d;
  assign w_act  = r_pend & r_mask;
  assign w_req  = r_gie & (|w_act);

  irq_controller_prio_enc #(
    .NSRC (NSRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .act   (w_act),
    .id    (w_win_id),
    .valid (w_win_vld)
  );

  // iack is honoured in REQ even if req dropped this very cycle: the core
  // has already vectored, so the winner (if any) is retired anyway.
  assign w_take     = (r_state == ST_REQ) && iack;
  assign w_take_clr = (w_take && w_win_vld) ? (NSRC'(1) << w_win_id) : '0;
  assign w_bus_clr  = (we && (addr == c_addr_pend)) ? wd[NSRC-1:0] : '0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (iack)        w_state_nxt = ST_SVC;
        else if (!w_req) w_state_nxt = ST_IDLE;
      end
      ST_SVC:  if (ret) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_d <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_gie   <= 1'b0;
      r_cause <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_src_d <= src_req;
      r_state <= w_state_nxt;
      // A fresh edge outranks any clear in the same cycle.
      r_pend  <= (r_pend & ~(w_bus_clr | w_take_clr)) | w_rise;
      if (w_take) r_cause <= w_win_id;
      if (we && (addr == c_addr_mask)) r_mask <= wd[NSRC-1:0];
      if (we && (addr == c_addr_ctrl)) r_gie  <= wd[0];
    end
  end

  assign irq = (r_state == ST_REQ);

  always_comb begin
    rd = '0;
    unique case (addr)
      c_addr_pend:  rd[NSRC-1:0] = r_pend;
      c_addr_mask:  rd[NSRC-1:0] = r_mask;
      c_addr_cause: begin
        rd[ID_W-1:0]           = r_cause;
        rd[c_cause_insvc_bit]  = (r_state == ST_SVC);
      end
      c_addr_ctrl:  rd[0] = r_gie;
      default:      rd = '0;
    endcase
  end

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Self-checking bench for irq_controller: directed scenarios
//               followed by randomized traffic, all compared each cycle with
//               a behavioural model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int NSRC = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] src_req = '0;
  logic            irq;
  logic            iack = 1'b0;
  logic            ret = 1'b0;
  logic            we = 1'b0;
  logic [1:0]      addr = 2'd0;
  logic [31:0]     wd = '0;
  logic [31:0]     rd;

  int passed = 0;
  int total  = 0;

  // Behavioural model: pending set, enables, and a simple "mode"
  // (0 waiting, 1 asking the core, 2 core in handler).
  logic [NSRC-1:0] m_pend, m_mask, m_prev;
  logic            m_gie;
  int              m_mode;
  int              m_cause;

  irq_controller #(.NSRC(NSRC), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_req (src_req),
    .irq     (irq),
    .iack    (iack),
    .ret     (ret),
    .we      (we),
    .addr    (addr),
    .wd      (wd),
    .rd      (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 1'b0; m_mode = 0; m_cause = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v = 32'(m_pend);
      2'd1: v = 32'(m_mask);
      2'd2: v = 32'(m_cause) | ((m_mode == 2) ? 32'h8000_0000 : 32'h0);
      default: v = {31'b0, m_gie};
    endcase
    return v;
  endfunction

  // One clock edge of the controller's rules, using the inputs as driven.
  task automatic model_step();
    logic [NSRC-1:0] act, clr;
    bit   req;
    int   win;
    if (rst) begin
      model_reset();
      return;
    end
    act = m_pend & m_mask;
    req = m_gie && (act != 0);
    win = 0;
    for (int i = 0; i < NSRC; i++) if (act[i]) begin win = i; break; end
    clr = '0;
    if (m_mode == 0) begin
      if (req) m_mode = 1;
    end else if (m_mode == 1) begin
      if (iack) begin
        m_mode  = 2;
        m_cause = win;
        if (act != 0) clr[win] = 1'b1;
      end else if (!req) m_mode = 0;
    end else begin
      if (ret) m_mode = 0;
    end
    if (we && addr == 2'd0) clr = clr | wd[NSRC-1:0];
    m_pend = (m_pend & ~clr) | (src_req & ~m_prev);
    if (we && addr == 2'd1) m_mask = wd[NSRC-1:0];
    if (we && addr == 2'd3) m_gie  = wd[0];
    m_prev = src_req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq", {31'b0, irq}, {31'b0, (m_mode == 1)});
    check("rd", rd, model_rd(addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick();
    we = 1'b0; addr = 2'd0; wd = '0;
  endtask

  task automatic pulse_iack();
    iack = 1'b1; tick(); iack = 1'b0;
  endtask

  task automatic pulse_ret();
    ret = 1'b1; tick(); ret = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a; #1;
    check(tag, rd, exp);
    check({tag, "_model"}, rd, model_rd(a));
    addr = 2'd0;
  endtask

  initial begin
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    read_chk("rst_pend", 2'd0, 32'h0);
    read_chk("rst_mask", 2'd1, 32'h0);
    read_chk("rst_cause", 2'd2, 32'h0);
    read_chk("rst_ctrl", 2'd3, 32'h0);

    // Single source, full mask, global enable
    wr(2'd1, 32'hF);
    wr(2'd3, 32'h1);
    src_req = 4'b0100; tick();
    check("t2_irq_k", {31'b0, irq}, 32'h0);
    src_req = 4'b0000; tick();
    check("t2_irq_k1", {31'b0, irq}, 32'h1);
    pulse_iack();
    check("t2_irq_ack", {31'b0, irq}, 32'h0);
    read_chk("t2_cause", 2'd2, 32'h8000_0002);
    read_chk("t2_pend", 2'd0, 32'h0);
    pulse_ret();

    // Two simultaneous sources: lowest index first
    src_req = 4'b1010; tick();
    src_req = 4'b0000; tick();
    check("t3_irq", {31'b0, irq}, 32'h1);
    pulse_iack();
    read_chk("t3_cause1", 2'd2, 32'h8000_0001);
    pulse_ret();
    check("t3_idle_gap", {31'b0, irq}, 32'h0);
    tick();
    check("t3_reassert", {31'b0, irq}, 32'h1);
    pulse_iack();
    read_chk("t3_cause3", 2'd2, 32'h8000_0003);
    pulse_ret();

    // Masked source stays pending until enabled
    wr(2'd1, 32'h1);
    src_req = 4'b0100; tick();
    src_req = 4'b0000; tick(); tick();
    check("t4_masked", {31'b0, irq}, 32'h0);
    read_chk("t4_pend", 2'd0, 32'h4);
    wr(2'd1, 32'h4);
    check("t4_wr_cycle", {31'b0, irq}, 32'h0);
    tick();
    check("t4_irq", {31'b0, irq}, 32'h1);

    // W1C all pending while requesting, with a new edge on src0 that cycle
    src_req = 4'b0001;
    wr(2'd0, 32'hF);
    src_req = 4'b0000;
    read_chk("t5_pend_kept", 2'd0, 32'h1);
    tick();
    check("t5_irq_drop", {31'b0, irq}, 32'h0);

    // No nesting during service; stray pulses ignored
    wr(2'd1, 32'hF);
    tick();
    check("t6_irq", {31'b0, irq}, 32'h1);
    pulse_iack();
    src_req = 4'b0001; tick();
    src_req = 4'b0000; tick(); tick();
    check("t6_svc_hold", {31'b0, irq}, 32'h0);
    read_chk("t6_svc_pend", 2'd0, 32'h1);
    pulse_ret();
    tick();
    check("t6_after_ret", {31'b0, irq}, 32'h1);
    pulse_ret();
    check("t6_stray_ret", {31'b0, irq}, 32'h1);
    pulse_iack();
    pulse_ret();
    pulse_iack();
    check("t6_stray_iack", {31'b0, irq}, 32'h0);
    read_chk("t6_cause_idle", 2'd2, 32'h0);

    // Asynchronous reset while requesting
    src_req = 4'b0010; tick();
    src_req = 4'b0000; tick();
    check("t1_req", {31'b0, irq}, 32'h1);
    rst = 1'b1; #1;
    check("t1_irq_async", {31'b0, irq}, 32'h0);
    model_reset();
    read_chk("t1_pend", 2'd0, 32'h0);
    read_chk("t1_mask", 2'd1, 32'h0);
    read_chk("t1_cause", 2'd2, 32'h0);
    read_chk("t1_ctrl", 2'd3, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic against the model
    wr(2'd1, 32'hF);
    wr(2'd3, 32'h1);
    for (int n = 0; n < 400; n++) begin
      src_req = 4'($urandom);
      iack    = ($urandom_range(0, 3) == 0);
      ret     = ($urandom_range(0, 3) == 0);
      we      = ($urandom_range(0, 5) == 0);
      addr    = 2'($urandom);
      wd      = $urandom;
      if (we && addr == 2'd3 && $urandom_range(0, 1) == 1) wd[0] = 1'b1;
      tick();
    end
    iack = 1'b0; ret = 1'b0; we = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_irq_controller
`default_nettype wire
